// File: rtl/sar_adc_ctrl_if.sv
// Control/front-end signal bundle for the SAR ADC sequencer.
// The slave modport is the sequencer's view; master is the system/analog side.
interface sar_adc_ctrl_if #(
    parameter int N_BITS = 10
);
    logic              start;
    logic              comp_in;
    logic              sample_en;
    logic [N_BITS-1:0] dac_code;
    logic              busy;
    logic [N_BITS-1:0] result;
    logic              result_valid;
    logic              overrun;

    modport slave (
        input  start, comp_in,
        output sample_en, dac_code, busy, result, result_valid, overrun
    );

    modport master (
        output start, comp_in,
        input  sample_en, dac_code, busy, result, result_valid, overrun
    );
endinterface

// File: rtl/sar_adc_ctrl.sv
// SAR ADC sequencer: sample window, MSB-first binary search on comp_in,
// registered result with a one-cycle valid pulse.
module sar_adc_ctrl #(
    parameter int N_BITS        = 10,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    sar_adc_ctrl_if.slave bus
);
    localparam int SCNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int TCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int BIT_W  = $clog2(N_BITS);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [SCNT_W-1:0]   r_scnt, w_scnt_nxt;
    logic [TCNT_W-1:0]   r_tcnt, w_tcnt_nxt;
    logic [BIT_W-1:0]    r_bit, w_bit_nxt;
    logic [N_BITS-1:0]   r_dac, w_dac_nxt;
    logic [N_BITS-1:0]   r_result, w_result_nxt;
    logic                r_sample_en, w_sample_en_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_overrun, w_overrun_nxt;
    logic [N_BITS-1:0]   w_trial;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_scnt      <= '0;
            r_tcnt      <= '0;
            r_bit       <= '0;
            r_dac       <= '0;
            r_result    <= '0;
            r_sample_en <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_scnt      <= w_scnt_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_bit       <= w_bit_nxt;
            r_dac       <= w_dac_nxt;
            r_result    <= w_result_nxt;
            r_sample_en <= w_sample_en_nxt;
            r_busy      <= w_busy_nxt;
            r_valid     <= w_valid_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // All outputs are computed one cycle ahead so they leave the block registered.
    always_comb begin
        w_state_nxt     = r_state;
        w_scnt_nxt      = r_scnt;
        w_tcnt_nxt      = r_tcnt;
        w_bit_nxt       = r_bit;
        w_dac_nxt       = r_dac;
        w_result_nxt    = r_result;
        w_sample_en_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_valid_nxt     = 1'b0;
        w_overrun_nxt   = 1'b0;
        w_trial         = r_dac;

        case (r_state)
            IDLE, DONE: begin
                w_dac_nxt = '0;
                if (bus.start) begin
                    w_state_nxt     = SAMPLE;
                    w_scnt_nxt      = '0;
                    w_sample_en_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SAMPLE: begin
                w_overrun_nxt = bus.start;
                w_busy_nxt    = 1'b1;
                if (r_scnt == SCNT_W'(SAMPLE_CYCLES - 1)) begin
                    w_state_nxt            = CONV;
                    w_tcnt_nxt             = '0;
                    w_bit_nxt              = BIT_W'(N_BITS - 1);
                    w_dac_nxt              = '0;
                    w_dac_nxt[N_BITS-1]    = 1'b1;
                end else begin
                    w_scnt_nxt      = r_scnt + 1'b1;
                    w_sample_en_nxt = 1'b1;
                end
            end
            CONV: begin
                w_overrun_nxt = bus.start;
                w_busy_nxt    = 1'b1;
                if (r_tcnt == TCNT_W'(SETTLE_CYCLES - 1)) begin
                    w_tcnt_nxt = '0;
                    if (!bus.comp_in) w_trial[r_bit] = 1'b0;
                    if (r_bit == '0) begin
                        w_state_nxt  = DONE;
                        w_result_nxt = w_trial;
                        w_valid_nxt  = 1'b1;
                        w_busy_nxt   = 1'b0;
                    end else begin
                        w_trial[r_bit - 1'b1] = 1'b1;
                        w_bit_nxt             = r_bit - 1'b1;
                    end
                    w_dac_nxt = w_trial;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.sample_en    = r_sample_en;
    assign bus.dac_code     = r_dac;
    assign bus.busy         = r_busy;
    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;
    assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: default instance plus an 8-bit/slow-settle variant,
// both driven by an ideal comparator model comp_in = (V >= dac_code).
module tb_sar_adc_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [9:0] V = '0;
    logic [7:0] V2 = '0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sar_adc_ctrl_if #(.N_BITS(10)) bus();
    sar_adc_ctrl_if #(.N_BITS(8))  bus2();

    assign bus.comp_in  = (V >= bus.dac_code);
    assign bus2.comp_in = (V2 >= bus2.dac_code);

    sar_adc_ctrl #(.N_BITS(10), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    sar_adc_ctrl #(.N_BITS(8), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Start with one pulse, then check the full 15-cycle window; ends in cycle 15.
    task automatic run_conv(input logic [9:0] v, input string tag);
        V = v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c <= 15; c++) begin
            checks++;
            if (bus.result_valid !== (c == 14)) begin
                errors++;
                $display("FAIL %s valid c=%0d: got %b expected %b", tag, c, bus.result_valid, (c == 14));
            end
            checks++;
            if (bus.busy !== (c < 14)) begin
                errors++;
                $display("FAIL %s busy c=%0d: got %b expected %b", tag, c, bus.busy, (c < 14));
            end
            if (c == 14) begin
                checks++;
                if (bus.result !== v) begin
                    errors++;
                    $display("FAIL %s result: got %h expected %h", tag, bus.result, v);
                end
            end
            if (c < 15) tick();
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.sample_en, bus.dac_code, bus.busy, bus.result, bus.result_valid, bus.overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {bus.sample_en, bus.dac_code, bus.busy, bus.result, bus.result_valid, bus.overrun});
        end
        bus.start = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: got busy %b expected 0", bus.busy);
        end
        bus.start = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_trace();
        logic [9:0] exp_seq [10] = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0,
                                     10'h2B0, 10'h2B8, 10'h2B4, 10'h2B6, 10'h2B5};
        V = 10'h2B5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c <= 15; c++) begin
            if (c < 4) begin
                chk("trace_sample_en", 16'(bus.sample_en), 16'h1);
                chk("trace_dac_sample", 16'(bus.dac_code), 16'h0);
            end else if (c < 14) begin
                chk("trace_dac", 16'(bus.dac_code), 16'(exp_seq[c-4]));
                chk("trace_sample_en_conv", 16'(bus.sample_en), 16'h0);
            end
            chk("trace_valid", 16'(bus.result_valid), 16'(c == 14));
            if (c == 14) begin
                chk("trace_result", 16'(bus.result), 16'h2B5);
                chk("trace_dac_done", 16'(bus.dac_code), 16'h2B5);
            end
            if (c == 15) chk("trace_dac_idle", 16'(bus.dac_code), 16'h0);
            if (c < 15) tick();
        end
    endtask

    task automatic test_endpoints();
        run_conv(10'h000, "zero");
        tick();
        run_conv(10'h3FF, "full");
        tick();
    endtask

    task automatic test_overrun();
        V = 10'h155;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            bus.start = (c == 8);
            chk("ovr_overrun", 16'(bus.overrun), 16'(c == 9));
            chk("ovr_valid", 16'(bus.result_valid), 16'(c == 14));
            if (c == 14) chk("ovr_result", 16'(bus.result), 16'h155);
            if (c > 14) begin
                chk("ovr_no_restart_busy", 16'(bus.busy), 16'h0);
                chk("ovr_no_restart_sample", 16'(bus.sample_en), 16'h0);
            end
            tick();
        end
        bus.start = 1'b0;
    endtask

    task automatic test_async_reset();
        V = 10'h2B5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        #3;
        reset = 1'b1;
        #1;
        chk("areset_busy", 16'(bus.busy), 16'h0);
        chk("areset_dac", 16'(bus.dac_code), 16'h0);
        chk("areset_result", 16'(bus.result), 16'h0);
        chk("areset_misc", 16'({bus.sample_en, bus.result_valid, bus.overrun}), 16'h0);
        tick();
        reset = 1'b0;
        run_conv(10'h0AA, "after_reset");
        tick();
    endtask

    task automatic test_back_to_back();
        V = 10'h3C3;
        bus.start = 1'b1;
        tick();
        for (int c = 0; c <= 44; c++) begin
            chk("b2b_valid", 16'(bus.result_valid), 16'((c % 15) == 14));
            chk("b2b_overrun", 16'(bus.overrun), 16'((c % 15) != 0));
            chk("b2b_sample_en", 16'(bus.sample_en), 16'((c % 15) < 4));
            if ((c % 15) == 14) chk("b2b_result", 16'(bus.result), 16'h3C3);
            if (c == 44) bus.start = 1'b0;
            tick();
        end
        chk("b2b_idle_busy", 16'(bus.busy), 16'h0);
        tick();
    endtask

    task automatic test_variant();
        V2 = 8'hA5;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int c = 0; c <= 28; c++) begin
            if (c < 2) chk("var_sample_en", 16'(bus2.sample_en), 16'h1);
            if (c >= 2 && c <= 4) chk("var_dac_msb", 16'(bus2.dac_code), 16'h80);
            if (c >= 5 && c <= 7) chk("var_dac_b6", 16'(bus2.dac_code), 16'hC0);
            chk("var_valid", 16'(bus2.result_valid), 16'(c == 26));
            if (c == 26) begin
                chk("var_result", 16'(bus2.result), 16'hA5);
                chk("var_busy_done", 16'(bus2.busy), 16'h0);
            end
            tick();
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus2.start = 1'b0;
        #2;
        test_reset();
        test_trace();
        test_endpoints();
        test_overrun();
        test_async_reset();
        test_back_to_back();
        test_variant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Sequencer for the 10-bit SAR ADC successive-approximation register path. It accepts a start request and drives the sample/hold enable for a fixed acquisition window. It then walks the trial DAC code from MSB to LSB, resolving each bit from the comparator output. The block delivers the final code with a one-cycle valid pulse and sits between the system control logic and the analog comparator/DAC front end.

Parameters:
N_BITS, 10, conversion resolution in bits; legal range 2..16
SAMPLE_CYCLES, 4, number of cycles sample_en is held high; must be >= 1
SETTLE_CYCLES, 1, cycles each trial code is held before comp_in is sampled; must be >= 1

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  conversion request; sampled on the rising edge of clk
comp_in  input  1  comparator output; 1 means analog input >= DAC(dac_code)
sample_en  output  1  sample/hold switch enable
dac_code  output  N_BITS  trial code driven to the DAC
busy  output  1  high while a conversion is in progress
result  output  N_BITS  last completed conversion code
result_valid  output  1  one-cycle pulse when result updates
overrun  output  1  one-cycle pulse when start is rejected

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). All outputs are registered.
- Reset (asserted at any time, including mid-conversion): state=IDLE, sample_en=0, dac_code=0, busy=0, result=0, result_valid=0, overrun=0, and internal counters cleared. start is ignored while reset is high. The first start can be accepted on the first rising edge after reset deasserts.
- States: IDLE, SAMPLE, CONV, DONE.
- IDLE: dac_code=0, sample_en=0, busy=0. start=1 at edge E0 moves to SAMPLE.
- SAMPLE: sample_en=1, busy=1, dac_code=0, for exactly SAMPLE_CYCLES cycles. On the last edge, go to CONV with bit index i=N_BITS-1 and dac_code set to only the MSB.
- CONV: busy=1, sample_en=0. Each trial code is held for SETTLE_CYCLES cycles. On the final settle edge, comp_in is sampled:
  - If comp_in=1, bit i is kept; if comp_in=0, bit i is cleared.
  - If i>0, bit i-1 is set in the same edge and i decrements.
  - If i==0, the resolved code is loaded into result, result_valid=1, busy=0, and the state moves to DONE.
  - comp_in is ignored on all other edges.
- DONE: lasts one cycle; result_valid=1 and busy=0. dac_code holds the final code. Next state is IDLE, or SAMPLE if start=1, which allows back-to-back conversions.
- Latency: result_valid is high in the cycle after edge E0 + SAMPLE_CYCLES + N_BITS*SETTLE_CYCLES. With defaults this is 14 edges after the start edge; the conversion period is 15 cycles.
- busy timing: rises in the cycle after E0, falls in the same cycle result_valid rises.
- start rejection: start=1 in SAMPLE or CONV is ignored and produces a one-cycle overrun pulse on the following cycle. The conversion in progress is unaffected.
- start held high continuously: a new conversion is accepted from every IDLE or DONE state. overrun pulses on every busy edge where start is high.
- result retains its value until the next result_valid; it is never partially updated.
- Width rules: dac_code and result are N_BITS unsigned. Bit counter is $clog2(N_BITS) wide. Settle and sample counters are sized for their parameter, with no wrap beyond the terminal count.

Test Plan:
- Bench comparator model with comp_in=(V>=dac_code), V=0x2B5, single start pulse -> dac_code sequence 0x200,0x300,0x280,0x2C0,0x2A0,0x2B0,0x2B8,0x2B4,0x2B6,0x2B5; result=0x2B5; result_valid high for exactly 1 cycle, 14 edges after start.
- Endpoints: V=0 -> result=0x000; V=1023 -> result=0x3FF; busy low in the result_valid cycle in both cases.
- start pulsed during CONV (bit 5) with V=0x155 -> overrun 1-cycle pulse; result=0x155 at the unchanged time; no second conversion starts.
- reset asserted mid-CONV (between clock edges) -> all outputs 0 immediately, without waiting for a clock edge; result does not retain the prior value. After release, start with V=0x0AA -> result=0x0AA on schedule.
- start held high continuously, V=0x3C3 -> result_valid pulses every 15 cycles; sample_en rises in the cycle after each DONE; overrun pulses on every busy edge.
- Parameter variant N_BITS=8, SAMPLE_CYCLES=2, SETTLE_CYCLES=3, V=0xA5 -> each trial code held 3 cycles; result=0xA5 with result_valid 26 edges after start.
